branch_trace_checker: RTL

- Synthesizable branch-resolution monitor that observes the core's EX-stage branch outcome every cycle.
- Independently recomputes the expected decision and target for all six RV32I conditional branches, counts events and flags mismatches.
- Logs each branch into a circular trace buffer readable by the debug/bench side.
- Successor to ad-hoc BEQ-only diagnosis: parametrised in XLEN and trace depth, with a freeze-on-error mode.

---
 rtl/branch_trace_checker.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/branch_trace_checker.sv
// Branch-resolution monitor: recomputes RV32I branch outcomes,
// counts events, flags mismatches and logs them to a trace ring.
module branch_trace_checker #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic              freeze_on_err_i,
    input  logic              br_valid_i,
    input  logic [2:0]        br_funct3_i,
    input  logic [XLEN-1:0]   br_pc_i,
    input  logic [XLEN-1:0]   br_imm_i,
    input  logic [XLEN-1:0]   br_rs1_i,
    input  logic [XLEN-1:0]   br_rs2_i,
    input  logic              br_taken_i,
    input  logic [XLEN-1:0]   br_target_i,
    input  logic              rd_en_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [XLEN+5:0]   rd_data_o,
    output logic              rd_valid_o,
    output logic [CNT_W-1:0]  branch_cnt_o,
    output logic [CNT_W-1:0]  taken_cnt_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [IDX_W:0]    entries_o,
    output logic              overflow_o,
    output logic              err_o,
    output logic [XLEN-1:0]   first_err_pc_o,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ARMED  = 2'b01,
        FROZEN = 2'b10
    } state_t;

    localparam logic [IDX_W:0]   FULL = (IDX_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CMAX = '1;

    state_t            state, state_nxt;
    logic              exp_taken, illegal;
    logic [XLEN-1:0]   exp_target;
    logic [1:0]        kind;
    logic              rec, rec_err;
    logic [IDX_W-1:0]  wptr, raddr;
    logic              rd_hit;
    logic [XLEN+5:0]   entry;
    logic [XLEN+5:0]   mem [DEPTH];

    assign exp_target = br_pc_i + br_imm_i;
    assign state_o    = state;

    // Reference branch decision from the forwarded operands
    always_comb begin
        illegal   = 1'b0;
        exp_taken = 1'b0;
        unique case (br_funct3_i)
            3'b000: exp_taken = (br_rs1_i == br_rs2_i);
            3'b001: exp_taken = (br_rs1_i != br_rs2_i);
            3'b100: exp_taken = ($signed(br_rs1_i) <  $signed(br_rs2_i));
            3'b101: exp_taken = ($signed(br_rs1_i) >= $signed(br_rs2_i));
            3'b110: exp_taken = (br_rs1_i <  br_rs2_i);
            3'b111: exp_taken = (br_rs1_i >= br_rs2_i);
            default: illegal  = 1'b1;
        endcase
    end

    // Classify the event; target only matters for taken branches
    always_comb begin
        kind = 2'b00;
        if (illegal)
            kind = 2'b11;
        else if (br_taken_i != exp_taken)
            kind = 2'b01;
        else if (br_taken_i && (br_target_i != exp_target))
            kind = 2'b10;
    end

    assign rec     = (state == ARMED) && br_valid_i && !clr_i;
    assign rec_err = rec && (kind != 2'b00);
    assign entry   = {kind, exp_taken, br_funct3_i, br_pc_i};

    // Next-state logic; clear always re-arms according to en_i
    always_comb begin
        state_nxt = state;
        if (clr_i)
            state_nxt = en_i ? ARMED : IDLE;
        else begin
            unique case (state)
                IDLE:    if (en_i) state_nxt = ARMED;
                ARMED: begin
                    if (rec_err && freeze_on_err_i)
                        state_nxt = FROZEN;
                    else if (!en_i)
                        state_nxt = IDLE;
                end
                FROZEN:  state_nxt = FROZEN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Counters, write pointer and sticky status
    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            branch_cnt_o   <= '0;
            taken_cnt_o    <= '0;
            err_cnt_o      <= '0;
            entries_o      <= '0;
            wptr           <= '0;
            overflow_o     <= 1'b0;
            err_o          <= 1'b0;
            first_err_pc_o <= '0;
        end else if (rec) begin
            wptr <= wptr + IDX_W'(1);
            if (entries_o == FULL)
                overflow_o <= 1'b1;
            else
                entries_o <= entries_o + (IDX_W+1)'(1);
            if (branch_cnt_o != CMAX)
                branch_cnt_o <= branch_cnt_o + CNT_W'(1);
            if (br_taken_i && (taken_cnt_o != CMAX))
                taken_cnt_o <= taken_cnt_o + CNT_W'(1);
            if (rec_err) begin
                if (err_cnt_o != CMAX)
                    err_cnt_o <= err_cnt_o + CNT_W'(1);
                if (!err_o)
                    first_err_pc_o <= br_pc_i;
                err_o <= 1'b1;
            end
        end
    end

    // Trace storage, contents are not reset
    always_ff @(posedge clk) begin
        if (rec)
            mem[wptr] <= entry;
    end

    assign raddr  = wptr - entries_o[IDX_W-1:0] + rd_idx_i;
    assign rd_hit = ({1'b0, rd_idx_i} < entries_o);

    // Registered read relative to the oldest valid entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
        end else if (rd_en_i) begin
            rd_valid_o <= rd_hit;
            rd_data_o  <= rd_hit ? mem[raddr] : '0;
        end else begin
            rd_valid_o <= 1'b0;
        end
    end

endmodule
